id_issue_fifo: RTL and testbench
================================

# id_issue_fifo

Parametrised buffer between the decoder and the issue stage. It replaces the single ID/issue pipeline register with a DEPTH-entry in-order FIFO of decoded scoreboard entries. It also caps how many control-flow instructions may be resident at once. Decoded instructions enter through a valid/ready handshake and leave in program order when the issue stage acknowledges them. A flush empties the whole buffer in one cycle.

## Interface
Parameters:
- DEPTH, default 2: number of entries. Must be a power of two, ≥ 2.
- MAX_CTRL_FLOW, default 1: maximum control-flow entries resident at once, range 1..DEPTH. 0 disables the limit.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- flush_i  in  1  drop all entries, including any written this cycle
- decoded_entry_i  in  ariane_pkg::scoreboard_entry_t  decoded instruction
- decoded_is_ctrl_flow_i  in  1  the decoded instruction is branch/jump
- decoded_valid_i  in  1  decoder offers an entry
- decoded_ready_o  out  1  buffer accepts the entry this cycle (fetch acknowledge)
- issue_entry_o  out  ariane_pkg::scoreboard_entry_t  head entry
- issue_entry_valid_o  out  1  head entry valid
- is_ctrl_flow_o  out  1  head entry is control flow
- issue_instr_ack_i  in  1  issue stage consumes the head this cycle
- usage_o  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH
- ctrl_flow_cnt_o  out  $clog2(DEPTH)+1  number of resident control-flow entries

## Operation
Storage:
- DEPTH slots, each holding {sbe, is_ctrl_flow}.
- Read pointer and write pointer, each $clog2(DEPTH) bits, wrapping naturally modulo DEPTH.
- Occupancy counter `cnt`, $clog2(DEPTH)+1 bits.
- Control-flow counter `cf_cnt`, $clog2(DEPTH)+1 bits.

Definitions:
- pop = issue_instr_ack_i && cnt != 0. An ack while empty is ignored: no pointer or counter change, no underflow.
- head_cf = slot[rd].is_ctrl_flow && cnt != 0.
- space = (cnt < DEPTH) || pop.
- cf_ok = (MAX_CTRL_FLOW == 0) || !decoded_is_ctrl_flow_i || (cf_cnt − (pop && head_cf) < MAX_CTRL_FLOW).
- decoded_ready_o = space && cf_ok. It does not depend on decoded_valid_i or flush_i.
- push = decoded_valid_i && decoded_ready_o.

Update (when not flushing):
- push writes slot[wr] and increments wr.
- pop increments rd.
- cnt += push − pop.
- cf_cnt += (push && decoded_is_ctrl_flow_i) − (pop && head_cf).

Simultaneous push and pop:
- Allowed at every occupancy, including full (cnt == DEPTH): a pop frees the slot in the same cycle.
- Allowed at cnt == 1: the old head leaves and the new entry becomes head next cycle.

Flush:
- On flush_i: rd ← 0, wr ← 0, cnt ← 0, cf_cnt ← 0.
- Slot contents are left unchanged.
- A handshake in the same cycle still completes (ready is asserted, so fetch advances), but the entry is discarded.
- Flush has priority over push and pop.

Outputs:
- issue_entry_o = slot[rd].sbe.
- is_ctrl_flow_o = slot[rd].is_ctrl_flow && cnt != 0.
- issue_entry_valid_o = cnt != 0.
- usage_o = cnt; ctrl_flow_cnt_o = cf_cnt.

Invariants:
- cf_cnt ≤ cnt ≤ DEPTH.
- cf_cnt ≤ MAX_CTRL_FLOW whenever the limit is enabled.

## Timing
- Reset values: all slots '0, pointers 0, cnt 0, cf_cnt 0.
- Output reset values: issue_entry_valid_o 0, is_ctrl_flow_o 0, issue_entry_o '0, usage_o 0, ctrl_flow_cnt_o 0.
- decoded_ready_o resets to 1 (empty buffer; with the limit disabled or a non-ctrl-flow input).
- Latency: an entry pushed at edge N is visible as head (valid=1) after edge N when the buffer was empty. No combinational bypass from decoded_entry_i to issue_entry_o.
- Combinational paths: issue_instr_ack_i → decoded_ready_o, and decoded_is_ctrl_flow_i → decoded_ready_o.
- Throughput: one push and one pop per cycle sustained, at any occupancy.
- Flush takes effect at the next edge. issue_entry_valid_o = 0 in the cycle after flush_i.
- Reset asserted mid-operation clears all state immediately (asynchronous); buffered entries are lost.

## Test plan
- Fill/drain, DEPTH=4, ack held low: push 4 entries with pc 0x100..0x10C. Required: decoded_ready_o=0 with usage_o=4. Then ack for 4 cycles: heads appear in order 0x100..0x10C, then valid=0 and usage_o=0.
- Full pass-through: with the buffer full, assert valid and ack together for 10 cycles. Required: ready=1 every cycle, usage_o stays 4, output order is preserved with no loss.
- Ctrl-flow limit, MAX_CTRL_FLOW=1: push a branch, then offer a second branch. Required: ready=0 until the first branch is acked. In the ack cycle ready=1, so the second branch is accepted, and ctrl_flow_cnt_o stays 1. Non-ctrl-flow entries are still accepted while blocked.
- Flush with concurrent push and ack at usage 3. Required: next cycle valid=0, usage_o=0, ctrl_flow_cnt_o=0; the pushed entry never appears at the output.
- Ack while empty, and async reset while at usage 2. Required: no underflow (usage_o stays 0); after reset all outputs 0 and decoded_ready_o=1.

Source files
------------

// File: rtl/ariane_pkg.sv
// Minimal stand-in for the core package: supplies the decoded scoreboard
// entry type carried by the ID/issue buffer. Field set is a compact subset
// sufficient for the buffer, which treats the entry as opaque payload.
package ariane_pkg;

    typedef struct packed {
        logic [63:0] pc;        // instruction address
        logic [2:0]  trans_id;  // scoreboard transaction id
        logic [3:0]  fu;        // functional unit selector
        logic [6:0]  op;        // operation code
        logic [5:0]  rs1;       // source register 1
        logic [5:0]  rs2;       // source register 2
        logic [5:0]  rd;        // destination register
        logic [63:0] result;    // immediate / result field
        logic        use_imm;   // operand b is the immediate
        logic        valid;     // result valid
    } scoreboard_entry_t;

endpackage

// File: rtl/id_issue_fifo.sv
// id_issue_fifo
// In-order DEPTH-entry buffer of decoded scoreboard entries between the
// decoder and the issue stage. Limits how many control-flow instructions may
// be resident at once and can be emptied in a single cycle by a flush.
//
// Ports:
//   clk_i                   clock, rising edge
//   rst_ni                  asynchronous active-low reset
//   flush_i                 drop all entries, including one written this cycle
//   decoded_entry_i         decoded instruction from the decoder
//   decoded_is_ctrl_flow_i  decoded instruction is a branch/jump
//   decoded_valid_i         decoder offers an entry
//   decoded_ready_o         entry accepted this cycle (fetch acknowledge)
//   issue_entry_o           head entry
//   issue_entry_valid_o     head entry valid
//   is_ctrl_flow_o          head entry is control flow
//   issue_instr_ack_i       issue stage consumes the head this cycle
//   usage_o                 number of valid entries, 0..DEPTH
//   ctrl_flow_cnt_o         number of resident control-flow entries
module id_issue_fifo #(
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned MAX_CTRL_FLOW = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  ariane_pkg::scoreboard_entry_t     decoded_entry_i,
    input  logic                              decoded_is_ctrl_flow_i,
    input  logic                              decoded_valid_i,
    output logic                              decoded_ready_o,
    output ariane_pkg::scoreboard_entry_t     issue_entry_o,
    output logic                              issue_entry_valid_o,
    output logic                              is_ctrl_flow_o,
    input  logic                              issue_instr_ack_i,
    output logic [$clog2(DEPTH):0]            usage_o,
    output logic [$clog2(DEPTH):0]            ctrl_flow_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        ariane_pkg::scoreboard_entry_t sbe;
        logic                          is_ctrl_flow;
    } slot_t;

    slot_t            mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cf_cnt_r;

    logic             not_empty_s;
    logic             pop_s;
    logic             push_s;
    logic             head_cf_s;
    logic             head_cf_pop_s;
    logic             space_s;
    logic             cf_ok_s;
    logic [CNT_W-1:0] cf_after_pop_s;

    // Handshake qualification: a pop frees a slot (and a branch credit) in the
    // same cycle, so a full or branch-saturated buffer still accepts on an ack.
    always_comb begin
        not_empty_s    = (cnt_r != {CNT_W{1'b0}});
        pop_s          = issue_instr_ack_i && not_empty_s;
        head_cf_s      = mem_r[rd_ptr_r].is_ctrl_flow && not_empty_s;
        head_cf_pop_s  = pop_s && head_cf_s;
        space_s        = (cnt_r < CNT_W'(DEPTH)) || pop_s;
        cf_after_pop_s = cf_cnt_r - CNT_W'(head_cf_pop_s);
        cf_ok_s        = 1'b1;
        if (MAX_CTRL_FLOW == 32'd0) begin
            cf_ok_s = 1'b1;
        end else if (!decoded_is_ctrl_flow_i) begin
            cf_ok_s = 1'b1;
        end else begin
            cf_ok_s = (cf_after_pop_s < CNT_W'(MAX_CTRL_FLOW));
        end
        // Ready is independent of valid and flush so fetch sees a stable ack.
        decoded_ready_o = space_s && cf_ok_s;
        push_s          = decoded_valid_i && decoded_ready_o;
    end

    // Storage, pointers and counters; flush wins over push and pop and leaves
    // slot contents untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            cf_cnt_r <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            cf_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= '{sbe: decoded_entry_i, is_ctrl_flow: decoded_is_ctrl_flow_i};
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            cnt_r    <= cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
            cf_cnt_r <= cf_cnt_r + CNT_W'(push_s && decoded_is_ctrl_flow_i)
                        - CNT_W'(head_cf_pop_s);
        end
    end

    // Head view comes straight from storage: no bypass from the decoder side.
    assign issue_entry_o       = mem_r[rd_ptr_r].sbe;
    assign issue_entry_valid_o = not_empty_s;
    assign is_ctrl_flow_o      = head_cf_s;
    assign usage_o             = cnt_r;
    assign ctrl_flow_cnt_o     = cf_cnt_r;

endmodule

// File: tb/tb_id_issue_fifo.sv
// Self-checking bench for id_issue_fifo (DEPTH=4, MAX_CTRL_FLOW=1).
// A queue of {pc, is_ctrl_flow} is the reference: acceptance, ordering and
// counters are derived from the queue contents every cycle.
module tb_id_issue_fifo;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned MAX_CF = 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    logic                          clk_i;
    logic                          rst_ni;
    logic                          flush_i;
    ariane_pkg::scoreboard_entry_t decoded_entry_i;
    logic                          decoded_is_ctrl_flow_i;
    logic                          decoded_valid_i;
    logic                          decoded_ready_o;
    ariane_pkg::scoreboard_entry_t issue_entry_o;
    logic                          issue_entry_valid_o;
    logic                          is_ctrl_flow_o;
    logic                          issue_instr_ack_i;
    logic [CNT_W-1:0]              usage_o;
    logic [CNT_W-1:0]              ctrl_flow_cnt_o;

    id_issue_fifo #(.DEPTH(DEPTH), .MAX_CTRL_FLOW(MAX_CF)) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .flush_i                (flush_i),
        .decoded_entry_i        (decoded_entry_i),
        .decoded_is_ctrl_flow_i (decoded_is_ctrl_flow_i),
        .decoded_valid_i        (decoded_valid_i),
        .decoded_ready_o        (decoded_ready_o),
        .issue_entry_o          (issue_entry_o),
        .issue_entry_valid_o    (issue_entry_valid_o),
        .is_ctrl_flow_o         (is_ctrl_flow_o),
        .issue_instr_ack_i      (issue_instr_ack_i),
        .usage_o                (usage_o),
        .ctrl_flow_cnt_o        (ctrl_flow_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] pc;
        logic        cf;
    } item_t;

    item_t model_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    logic  last_ready;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check against the queue, update at posedge.
    task automatic step(input logic v, input logic cf, input logic [63:0] pc,
                        input logic ack, input logic fl);
        int   n_cf;
        int   n_q;
        logic pop;
        logic head_cf_leaves;
        logic exp_ready;
        @(negedge clk_i);
        decoded_valid_i          = v;
        decoded_is_ctrl_flow_i   = cf;
        decoded_entry_i          = '0;
        decoded_entry_i.pc       = pc;
        decoded_entry_i.trans_id = 3'($urandom);
        decoded_entry_i.result   = {$urandom, $urandom};
        issue_instr_ack_i        = ack;
        flush_i                  = fl;
        #1;
        n_q  = model_q.size();
        n_cf = 0;
        foreach (model_q[i]) begin
            if (model_q[i].cf) n_cf++;
        end
        pop            = ack && (n_q != 0);
        head_cf_leaves = 1'b0;
        if (pop) head_cf_leaves = model_q[0].cf;
        // Room exists if not full or the head leaves now; a branch needs the
        // resident branch count (after this cycle's retirement) under the cap.
        exp_ready = ((n_q < int'(DEPTH)) || pop) &&
                    ((MAX_CF == 0) || !cf || ((n_cf - int'(head_cf_leaves)) < int'(MAX_CF)));
        check_eq("ready",  64'(decoded_ready_o), 64'(exp_ready));
        check_eq("valid",  64'(issue_entry_valid_o), 64'(n_q != 0));
        check_eq("usage",  64'(usage_o), 64'(n_q));
        check_eq("cf_cnt", 64'(ctrl_flow_cnt_o), 64'(n_cf));
        if (n_q != 0) begin
            check_eq("head_pc", issue_entry_o.pc, model_q[0].pc);
            check_eq("head_cf", 64'(is_ctrl_flow_o), 64'(model_q[0].cf));
        end else begin
            check_eq("head_cf_empty", 64'(is_ctrl_flow_o), 64'd0);
        end
        last_ready = decoded_ready_o;
        @(posedge clk_i);
        if (fl) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (v && exp_ready) model_q.push_back('{pc: pc, cf: cf});
        end
    endtask

    task automatic idle_inputs();
        decoded_valid_i        = 1'b0;
        decoded_is_ctrl_flow_i = 1'b0;
        decoded_entry_i        = '0;
        issue_instr_ack_i      = 1'b0;
        flush_i                = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 64'(issue_entry_valid_o), 64'd0);
        check_eq({tag, "_cf"},    64'(is_ctrl_flow_o), 64'd0);
        check_eq({tag, "_pc"},    issue_entry_o.pc, 64'd0);
        check_eq({tag, "_res"},   issue_entry_o.result, 64'd0);
        check_eq({tag, "_usage"}, 64'(usage_o), 64'd0);
        check_eq({tag, "_cfcnt"}, 64'(ctrl_flow_cnt_o), 64'd0);
        check_eq({tag, "_ready"}, 64'(decoded_ready_o), 64'd1);
    endtask

    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("rst");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Fill with ack low, then offer one more while full.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 64'h100 + 64'(4 * i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 64'h1F0, 1'b0, 1'b0);
        check_eq("full_ready", 64'(last_ready), 64'd0);
        // Drain in order.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);

        // Refill, then push and pop together while full.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 64'h200 + 64'(4 * i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 64'h300 + 64'(4 * i), 1'b1, 1'b0);
            check_eq("pass_ready", 64'(last_ready), 64'd1);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);

        // Branch cap: second branch waits until the first is acked.
        step(1'b1, 1'b1, 64'h400, 1'b0, 1'b0);
        step(1'b1, 1'b1, 64'h404, 1'b0, 1'b0);
        check_eq("cf_block", 64'(last_ready), 64'd0);
        step(1'b1, 1'b0, 64'h408, 1'b0, 1'b0);
        check_eq("noncf_pass", 64'(last_ready), 64'd1);
        step(1'b1, 1'b1, 64'h40C, 1'b1, 1'b0);
        check_eq("cf_ack_ready", 64'(last_ready), 64'd1);
        step(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);

        // Flush at usage 3 with a concurrent push and ack.
        step(1'b1, 1'b1, 64'h500, 1'b0, 1'b0);
        step(1'b1, 1'b0, 64'h504, 1'b0, 1'b0);
        step(1'b1, 1'b0, 64'h508, 1'b0, 1'b0);
        step(1'b1, 1'b0, 64'h600, 1'b1, 1'b1);
        step(1'b1, 1'b0, 64'h700, 1'b0, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);

        // Ack while empty.
        step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 64'h0, 1'b1, 1'b0);

        // Asynchronous reset at usage 2.
        step(1'b1, 1'b1, 64'h800, 1'b0, 1'b0);
        step(1'b1, 1'b0, 64'h804, 1'b0, 1'b0);
        @(negedge clk_i);
        idle_inputs();
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("arst");
        model_q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Randomised traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                 64'h1000 + 64'(4 * i), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 31) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
